// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the memory stage: icodes, status codes,
// FSM state encoding and the memory command bundle.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Status codes
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Memory stage FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  // Decoded memory access for one instruction
  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_sel.sv
// Combinational address / write-data / access-type selection by icode.
import y86_pkg::*;

module mem_sel (
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output mem_cmd_t    cmd
);

  // Stack pops read at the old SP (valA); everything else addresses valE.
  always_comb begin
    cmd = '0;
    case (icode)
      IRMMOVQ, IPUSHQ: begin
        cmd.wr    = 1'b1;
        cmd.addr  = valE;
        cmd.wdata = valA;
      end
      ICALL: begin
        cmd.wr    = 1'b1;
        cmd.addr  = valE;
        cmd.wdata = valP;
      end
      IMRMOVQ: begin
        cmd.rd   = 1'b1;
        cmd.addr = valE;
      end
      IRET, IPOPQ: begin
        cmd.rd   = 1'b1;
        cmd.addr = valA;
      end
      default: cmd = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: one instruction at a time, req/ack to data memory,
// bounded wait, sticky HALTED on any non-AOK final status.
import y86_pkg::*;

module mem_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [2:0]  in_stat,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic        cnd,
  output logic        out_valid,
  output logic [3:0]  out_icode,
  output logic [63:0] out_valE,
  output logic        out_cnd,
  output logic [63:0] valM,
  output logic [2:0]  stat,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata
);

  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_cmd_t cmd;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    icode_q, icode_d;
  logic [63:0]   valE_q, valE_d;
  logic          cnd_q, cnd_d;
  logic [63:0]   valM_q, valM_d;
  logic [2:0]    stat_q, stat_d;
  logic          we_q, we_d;
  logic          rd_q, rd_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;

  mem_sel u_sel (
    .icode (icode),
    .valE  (valE),
    .valA  (valA),
    .valP  (valP),
    .cmd   (cmd)
  );

  // Next-state: accept in IDLE, wait for ack or timeout in REQ, pulse in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    icode_d = icode_q;
    valE_d  = valE_q;
    cnd_d   = cnd_q;
    valM_d  = valM_q;
    stat_d  = stat_q;
    we_d    = we_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          icode_d = icode;
          valE_d  = valE;
          cnd_d   = cnd;
          valM_d  = '0;
          if (in_stat != SAOK) begin
            stat_d  = in_stat;
            state_d = ST_DONE;
          end else if ((cmd.wr || cmd.rd) && (cmd.addr > ADDR_MAX)) begin
            stat_d  = SADR;
            state_d = ST_DONE;
          end else if (cmd.wr || cmd.rd) begin
            // Command is frozen here so the bus stays stable across the wait.
            we_d    = cmd.wr;
            rd_d    = cmd.rd;
            addr_d  = cmd.addr;
            wdata_d = cmd.wdata;
            cnt_d   = '0;
            state_d = ST_REQ;
          end else begin
            stat_d  = SAOK;
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        // Ack wins over timeout when both land on the same edge.
        if (dmem_ack) begin
          valM_d  = rd_q ? dmem_rdata : 64'd0;
          stat_d  = SAOK;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          valM_d  = '0;
          stat_d  = SADR;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE:   state_d = (stat_q == SAOK) ? ST_IDLE : ST_HALTED;
      default:   state_d = ST_HALTED;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      icode_q <= '0;
      valE_q  <= '0;
      cnd_q   <= 1'b0;
      valM_q  <= '0;
      stat_q  <= '0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      icode_q <= icode_d;
      valE_q  <= valE_d;
      cnd_q   <= cnd_d;
      valM_q  <= valM_d;
      stat_q  <= stat_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign dmem_req   = (state_q == ST_REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign out_icode  = icode_q;
  assign out_valE   = valE_q;
  assign out_cnd    = cnd_q;
  assign valM       = valM_q;
  assign stat       = stat_q;

endmodule
